// File: rtl/wb_req_master_if.sv
// wb_if: pipelined Wishbone (B4) signal bundle shared by initiator and target.
// Rev 1.0
`default_nettype none

interface wb_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [3:0]        sel;
    logic [31:0]       dat_o;
    logic [31:0]       dat_i;
    logic              ack;
    logic              err;
    logic              stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_o,
        input  dat_i, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_o,
        output dat_i, ack, err, stall
    );
endinterface

`default_nettype wire

// File: rtl/wb_req_master.sv
// wb_req_master: single-outstanding pipelined Wishbone initiator with abort timeout.
// Rev 1.0
`default_nettype none

module wb_req_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_adr,
    input  logic [31:0]       req_dat,
    input  logic [3:0]        req_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_dat,
    output logic              rsp_err,
    output logic              rsp_timeout,
    wb_if.master              wb
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cyc_q;
    logic              stb_q;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [3:0]        sel_q;
    logic [31:0]       dat_q;
    logic [31:0]       rsp_dat_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    logic active;
    logic complete;
    logic abort;

    // A termination only counts once the strobe has been accepted (stall low).
    assign active   = (state_q == S_REQ) || (state_q == S_WAIT);
    assign complete = (wb.ack || wb.err) &&
                      ((state_q == S_WAIT) || ((state_q == S_REQ) && !wb.stall));
    assign abort    = active && !complete && (cnt_q >= TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            sel_q         <= '0;
            dat_q         <= '0;
            rsp_dat_q     <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        adr_q   <= req_adr & ~ADDR_W'(3);
                        sel_q   <= req_sel;
                        dat_q   <= req_we ? req_dat : 32'h0;
                        cnt_q   <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (complete || abort) begin
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        rsp_err_q     <= abort || wb.err;
                        rsp_timeout_q <= abort;
                        rsp_dat_q     <= (abort || wb.err || we_q) ? 32'h0 : wb.dat_i;
                        state_q       <= S_RSP;
                    end else begin
                        if (~&cnt_q) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if ((state_q == S_REQ) && !wb.stall) begin
                            stb_q   <= 1'b0;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RSP);
    assign rsp_dat     = rsp_dat_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    assign wb.cyc   = cyc_q;
    assign wb.stb   = stb_q;
    assign wb.we    = we_q;
    assign wb.adr   = adr_q;
    assign wb.sel   = sel_q;
    assign wb.dat_o = dat_q;

endmodule

`default_nettype wire
